fir_mac_scheduler: RTL

- Sequencer for a time-multiplexed FIR: one external multiply-accumulate unit shared across all FIR_LENGTH taps.
- Accepts one input sample per valid/ready handshake and writes it into an external circular sample RAM.
- Then issues FIR_LENGTH tap reads (sample and coefficient addresses plus MAC controls), waits out the MAC pipeline, captures the result and presents it on a valid/ready output.
- Sits between the sample source and the sample RAM, coefficient ROM and MAC datapath.

---
 rtl/fir_mac_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_scheduler.sv
// Sequencer for a time-multiplexed FIR sharing one external MAC across all taps.
// Optional sample bypass path is compiled in with `define FIR_BYPASS_EN.
//
// state  | meaning
// IDLE   | waiting for an input sample, o_din_ready follows i_en
// LOAD   | write the latched sample into the circular sample RAM
// MAC    | issue one tap per enabled cycle, k = 0..FIR_LENGTH-1
// DRAIN  | let the MAC pipeline settle, then capture the result
// OUT    | hold the result until the downstream takes it
module fir_mac_scheduler #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIR_LENGTH  = 128,
  parameter int MAC_LATENCY = 3,
  localparam int ADDR_W     = (FIR_LENGTH > 1) ? $clog2(FIR_LENGTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
`ifdef FIR_BYPASS_EN
  input  logic                  i_bypass,
`endif
  input  logic                  i_din_valid,
  output logic                  o_din_ready,
  input  logic [DATA_WIDTH-1:0] iv_din,
  output logic                  o_smp_we,
  output logic [ADDR_W-1:0]     ov_smp_waddr,
  output logic [DATA_WIDTH-1:0] ov_smp_wdata,
  output logic [ADDR_W-1:0]     ov_smp_raddr,
  output logic [ADDR_W-1:0]     ov_coef_raddr,
  output logic                  o_mac_en,
  output logic                  o_mac_clr,
  input  logic [DATA_WIDTH-1:0] iv_mac_acc,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_busy
);

  localparam int DCNT_W = $clog2(MAC_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(FIR_LENGTH - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(MAC_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                  state_q;
  logic [ADDR_W-1:0]       wr_ptr_q;
  logic [ADDR_W-1:0]       tap_q;
  logic [DCNT_W-1:0]       dcnt_q;
  logic [DATA_WIDTH-1:0]   sample_q;
  logic                    din_ready_q;
  logic                    smp_we_q;
  logic [ADDR_W-1:0]       smp_waddr_q;
  logic [DATA_WIDTH-1:0]   smp_wdata_q;
  logic [ADDR_W-1:0]       smp_raddr_q;
  logic [ADDR_W-1:0]       coef_raddr_q;
  logic                    mac_en_q;
  logic                    mac_clr_q;
  logic                    dout_valid_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    busy_q;
  logic                    bypass_q;

  logic [ADDR_W-1:0]       wr_ptr_d;
  logic [ADDR_W-1:0]       smp_raddr_d;
  logic [DATA_WIDTH-1:0]   capture_d;

  // Explicit wrap keeps the history ring correct for non power-of-two lengths.
  always_comb begin
    wr_ptr_d    = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + ADDR_W'(1);
    smp_raddr_d = (smp_raddr_q == '0) ? LAST_TAP : smp_raddr_q - ADDR_W'(1);
    capture_d   = bypass_q ? sample_q : iv_mac_acc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      tap_q        <= '0;
      dcnt_q       <= '0;
      sample_q     <= '0;
      din_ready_q  <= 1'b0;
      smp_we_q     <= 1'b0;
      smp_waddr_q  <= '0;
      smp_wdata_q  <= '0;
      smp_raddr_q  <= '0;
      coef_raddr_q <= '0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      bypass_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          din_ready_q <= i_en;
          if (i_din_valid && din_ready_q) begin
            sample_q    <= iv_din;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
`ifdef FIR_BYPASS_EN
            bypass_q    <= i_bypass;
`else
            bypass_q    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (i_en) begin
            smp_we_q    <= 1'b1;
            smp_waddr_q <= wr_ptr_q;
            smp_wdata_q <= sample_q;
            tap_q       <= '0;
            state_q     <= S_MAC;
            // Bypass jumps straight to the capture step of DRAIN.
            if (bypass_q) begin
              wr_ptr_q <= wr_ptr_d;
              dcnt_q   <= DRAIN_LAST;
              state_q  <= S_DRAIN;
            end
          end else begin
            smp_we_q <= 1'b0;
          end
        end
        S_MAC: begin
          smp_we_q <= 1'b0;
          if (i_en) begin
            mac_en_q     <= 1'b1;
            mac_clr_q    <= (tap_q == '0);
            coef_raddr_q <= tap_q;
            smp_raddr_q  <= (tap_q == '0) ? wr_ptr_q : smp_raddr_d;
            if (tap_q == LAST_TAP) begin
              wr_ptr_q <= wr_ptr_d;
              dcnt_q   <= '0;
              state_q  <= S_DRAIN;
            end else begin
              tap_q <= tap_q + ADDR_W'(1);
            end
          end else begin
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          smp_we_q  <= 1'b0;
          mac_en_q  <= 1'b0;
          mac_clr_q <= 1'b0;
          if (i_en) begin
            if (dcnt_q == DRAIN_LAST) begin
              dout_q       <= capture_d;
              dout_valid_q <= 1'b1;
              state_q      <= S_OUT;
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (i_dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= i_en;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_din_ready   = din_ready_q;
  assign o_smp_we      = smp_we_q;
  assign ov_smp_waddr  = smp_waddr_q;
  assign ov_smp_wdata  = smp_wdata_q;
  assign ov_smp_raddr  = smp_raddr_q;
  assign ov_coef_raddr = coef_raddr_q;
  assign o_mac_en      = mac_en_q;
  assign o_mac_clr     = mac_clr_q;
  assign o_dout_valid  = dout_valid_q;
  assign ov_dout       = dout_q;
  assign o_busy        = busy_q;

endmodule
